// File: rtl/image_frame_sequencer.sv
// Frame sequencer: meters raster lines into a 4-line-buffer window generator using line credits.
// Build macro IMG_SEQ_PAD_EN adds one zero line above and below the frame.
module image_frame_sequencer #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int NUM_LB     = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_s_data,
   input  logic        i_s_valid,
   output logic        o_s_ready,
   output logic [7:0]  o_pixel_data,
   output logic        o_pixel_data_valid,
   input  logic        i_intr,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_err,
   output logic [11:0] o_rows_out
);
   localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
`ifdef IMG_SEQ_PAD_EN
   localparam int PAD_LINES = 1;
`else
   localparam int PAD_LINES = 0;
`endif
   localparam int TOTAL_LINES = IMG_HEIGHT + 2 * PAD_LINES;
   localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDTH - 1);
   localparam logic [11:0]      LAST_IN_LINE = 12'(IMG_HEIGHT - 1 + PAD_LINES);
   localparam logic [11:0]      ROWS_DONE    = 12'(TOTAL_LINES - 2);
   localparam logic [2:0]       CRED_INIT    = 3'(NUM_LB);

   typedef enum logic [2:0] {IDLE, PAD_TOP, STREAM, PAD_BOT, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [11:0]      line_q, line_d;
   logic [2:0]       credits_q, credits_d;
   logic [11:0]      rows_q, rows_d;
   logic             err_q, err_d;
   logic [7:0]       pix_q, pix_d;
   logic             pix_valid_q, pix_valid_d;
   logic             done_q, done_d;

   logic busy, have_credit, ready, pad_wr, xfer, wr, line_start, line_end, intr_eff;

   // Credits only gate the start of a line; a started line always runs to completion.
   always_comb begin
      busy        = (state_q != IDLE);
      have_credit = (col_q != '0) || (credits_q != 3'd0);
      ready       = (state_q == STREAM) && have_credit;
`ifdef IMG_SEQ_PAD_EN
      pad_wr      = ((state_q == PAD_TOP) || (state_q == PAD_BOT)) && have_credit;
`else
      pad_wr      = 1'b0;
`endif
      xfer        = ready && i_s_valid;
      wr          = xfer || pad_wr;
      line_start  = wr && (col_q == '0);
      line_end    = wr && (col_q == COL_LAST);
      intr_eff    = i_intr && busy;
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      line_d      = line_q;
      credits_d   = credits_q;
      rows_d      = rows_q;
      err_d       = err_q;
      pix_d       = xfer ? i_s_data : 8'h00;
      pix_valid_d = wr;
      done_d      = 1'b0;

      if (wr) begin
         if (line_end) begin
            col_d  = '0;
            line_d = line_q + 12'd1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (intr_eff) begin
         rows_d = rows_q + 12'd1;
      end

      // A returned credit and a consumed credit in the same cycle cancel out.
      if (intr_eff && !line_start) begin
         if (credits_q == CRED_INIT) begin
            err_d = 1'b1;
         end else begin
            credits_d = credits_q + 3'd1;
         end
      end else if (line_start && !intr_eff) begin
         credits_d = credits_q - 3'd1;
      end

      case (state_q)
         IDLE: begin
            if (i_start) begin
               col_d     = '0;
               line_d    = '0;
               rows_d    = '0;
               err_d     = 1'b0;
               credits_d = CRED_INIT;
`ifdef IMG_SEQ_PAD_EN
               state_d   = PAD_TOP;
`else
               state_d   = STREAM;
`endif
            end
         end
`ifdef IMG_SEQ_PAD_EN
         PAD_TOP: if (line_end) state_d = STREAM;
         PAD_BOT: if (line_end) state_d = DRAIN;
`endif
         STREAM: begin
            if (line_end && (line_q == LAST_IN_LINE)) begin
`ifdef IMG_SEQ_PAD_EN
               state_d = PAD_BOT;
`else
               state_d = DRAIN;
`endif
            end
         end
         DRAIN: begin
            if (rows_q == ROWS_DONE) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         line_q      <= '0;
         credits_q   <= '0;
         rows_q      <= '0;
         err_q       <= 1'b0;
         pix_q       <= '0;
         pix_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         line_q      <= line_d;
         credits_q   <= credits_d;
         rows_q      <= rows_d;
         err_q       <= err_d;
         pix_q       <= pix_d;
         pix_valid_q <= pix_valid_d;
         done_q      <= done_d;
      end
   end

   assign o_s_ready          = ready;
   assign o_pixel_data       = pix_q;
   assign o_pixel_data_valid = pix_valid_q;
   assign o_busy             = busy;
   assign o_frame_done       = done_q;
   assign o_err              = err_q;
   assign o_rows_out         = rows_q;
endmodule

// File: tb/tb_image_frame_sequencer.sv
// Randomized bench for image_frame_sequencer (8x6 frame); expected stream and counts come
// from a line-level reference model, and a downstream model returns i_intr per held line.
module tb_image_frame_sequencer;
   localparam int W   = 8;
   localparam int H   = 6;
   localparam int NLB = 4;
`ifdef IMG_SEQ_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif
   localparam int L = H + 2 * PAD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  pix;
   logic        pix_valid;
   logic        intr = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        err;
   logic [11:0] rows_out;

   always #5 clk = ~clk;

   image_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LB(NLB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
      .o_pixel_data(pix), .o_pixel_data_valid(pix_valid), .i_intr(intr),
      .o_busy(busy), .o_frame_done(frame_done), .o_err(err), .o_rows_out(rows_out)
   );

   int n_pass = 0;
   int n_checks = 0;
   int cyc = 0;
   logic [7:0] src_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int intr_due[$];
   int n_acc, n_writes, n_spur, n_done, bad_lat, bad_done, lines_seen;
   int gate_pct, coincide_idx;
   bit auto_intr, force_intr, xfer_prev, busy_prev;
   logic [7:0] xfer_data;

   // One clock: observe outputs at the falling edge, then drive inputs for the next rising edge.
   task automatic step();
      bit x;
      @(negedge clk);
      cyc++;
      if (pix_valid === 1'b1) begin
         got_q.push_back(pix);
         n_writes++;
         if (!xfer_prev) n_spur++;
         else if (pix !== xfer_data) bad_lat++;
         if (n_writes % W == 0) begin
            lines_seen++;
            if (auto_intr && lines_seen >= 3) intr_due.push_back(cyc + 12);
         end
      end else if (xfer_prev) begin
         bad_lat++;
      end
      if (frame_done === 1'b1) begin
         n_done++;
         if (busy !== 1'b0 || !busy_prev) bad_done++;
      end
      busy_prev  = (busy === 1'b1);
      intr       = force_intr;
      force_intr = 1'b0;
      if (intr_due.size() > 0 && intr_due[0] <= cyc) begin
         void'(intr_due.pop_front());
         intr = 1'b1;
      end
      if (src_q.size() > 0 && $urandom_range(99) >= gate_pct) begin
         s_valid = 1'b1;
         s_data  = src_q[0];
      end else begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
      end
      x = s_valid && (s_ready === 1'b1);
      if (x && coincide_idx >= 0 && (n_acc + PAD * W) == coincide_idx) intr = 1'b1;
      xfer_prev = x;
      if (x) begin
         xfer_data = src_q.pop_front();
         n_acc++;
      end
   endtask

   task automatic apply_reset();
      start   = 1'b0;
      s_valid = 1'b0;
      intr    = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      intr_due.delete();
      xfer_prev = 1'b0;
   endtask

   task automatic new_frame(input int gate, input bit ai);
      src_q.delete(); exp_q.delete(); got_q.delete(); intr_due.delete();
      n_acc = 0; n_writes = 0; n_spur = 0; n_done = 0; bad_lat = 0; bad_done = 0;
      lines_seen = 0; xfer_prev = 1'b0; gate_pct = gate; auto_intr = ai; coincide_idx = -1;
      busy_prev = 1'b0;
      for (int i = 0; i < PAD * W; i++) exp_q.push_back(8'h00);
      for (int i = 0; i < H * W; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         src_q.push_back(v);
         exp_q.push_back(v);
      end
      for (int i = 0; i < PAD * W; i++) exp_q.push_back(8'h00);
      s_valid = 1'b0;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic run_until_done(input int budget);
      for (int c = 0; c < budget && n_done == 0; c++) step();
      for (int c = 0; c < 4; c++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", s_ready); else n_pass++;
      n_checks++; if ({pix_valid, pix} !== 9'h0) $display("FAIL reset_pixel: got %b/%h expected 0/00", pix_valid, pix); else n_pass++;
      n_checks++; if ({busy, frame_done, err} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {busy, frame_done, err}); else n_pass++;
      n_checks++; if (rows_out !== 12'd0) $display("FAIL reset_rows: got %0d expected 0", rows_out); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      $display("test_reset: done");
   endtask

   task automatic test_full_frame();
      int mism;
      new_frame(0, 1'b1);
      run_until_done(2000);
      mism = (got_q.size() == exp_q.size()) ? 0 : 1;
      foreach (got_q[i]) if (i < exp_q.size() && got_q[i] !== exp_q[i]) mism++;
      n_checks++; if (n_done !== 1) $display("FAIL full_done_count: got %0d expected 1", n_done); else n_pass++;
      n_checks++; if (bad_done !== 0) $display("FAIL full_done_busy: got %0d bad pulses expected 0", bad_done); else n_pass++;
      n_checks++; if (n_writes !== L * W) $display("FAIL full_writes: got %0d expected %0d", n_writes, L * W); else n_pass++;
      n_checks++; if (mism !== 0) $display("FAIL full_order: got %0d mismatches expected 0", mism); else n_pass++;
      n_checks++; if (rows_out !== 12'(L - 2)) $display("FAIL full_rows: got %0d expected %0d", rows_out, L - 2); else n_pass++;
      n_checks++; if (bad_lat !== 0) $display("FAIL full_latency: got %0d bad cycles expected 0", bad_lat); else n_pass++;
      n_checks++; if (n_spur !== 2 * PAD * W) $display("FAIL full_pad_writes: got %0d expected %0d", n_spur, 2 * PAD * W); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL full_idle: got busy %b expected 0", busy); else n_pass++;
      $display("test_full_frame: %0d writes, rows %0d", n_writes, rows_out);
   endtask

   task automatic test_credit_stall();
      int mism;
      apply_reset();
      new_frame(0, 1'b0);
      for (int c = 0; c < 150; c++) step();
      mism = 0;
      foreach (got_q[i]) if (i < exp_q.size() && got_q[i] !== exp_q[i]) mism++;
      n_checks++; if (n_writes !== NLB * W) $display("FAIL stall_writes: got %0d expected %0d", n_writes, NLB * W); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL stall_ready: got %b expected 0", s_ready); else n_pass++;
      n_checks++; if (mism !== 0) $display("FAIL stall_order: got %0d mismatches expected 0", mism); else n_pass++;
      force_intr = 1'b1;
      for (int c = 0; c < 60; c++) step();
      n_checks++; if (n_writes !== (NLB + 1) * W) $display("FAIL stall_release_writes: got %0d expected %0d", n_writes, (NLB + 1) * W); else n_pass++;
      n_checks++; if (rows_out !== 12'd1) $display("FAIL stall_rows: got %0d expected 1", rows_out); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL stall_ready_again: got %b expected 0", s_ready); else n_pass++;
      $display("test_credit_stall: %0d writes", n_writes);
   endtask

   task automatic test_intr_coincide();
      apply_reset();
      new_frame(0, 1'b0);
      coincide_idx = 3 * W;
      for (int c = 0; c < 150; c++) step();
      n_checks++; if (n_writes !== 5 * W) $display("FAIL coincide_writes: got %0d expected %0d", n_writes, 5 * W); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL coincide_ready: got %b expected 0", s_ready); else n_pass++;
      n_checks++; if ({err, rows_out} !== {1'b0, 12'd1}) $display("FAIL coincide_status: got err %b rows %0d expected err 0 rows 1", err, rows_out); else n_pass++;
      $display("test_intr_coincide: %0d writes", n_writes);
   endtask

   task automatic test_err();
      apply_reset();
      new_frame(100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         force_intr = 1'b1;
         step();
      end
      step(); step();
      n_checks++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else n_pass++;
      n_checks++; if (rows_out !== 12'd3) $display("FAIL err_rows: got %0d expected 3", rows_out); else n_pass++;
      start = 1'b1; step(); start = 1'b0; step(); step();
      n_checks++; if ({busy, err} !== 2'b11) $display("FAIL err_busy_start: got busy %b err %b expected 1 1", busy, err); else n_pass++;
      n_checks++; if (rows_out !== 12'd3) $display("FAIL err_start_ignored: got rows %0d expected 3", rows_out); else n_pass++;
      apply_reset();
      #1;
      n_checks++; if (err !== 1'b0) $display("FAIL err_reset_clear: got %b expected 0", err); else n_pass++;
      new_frame(100, 1'b0);
      n_checks++; if ({busy, err} !== 2'b10) $display("FAIL err_restart: got busy %b err %b expected 1 0", busy, err); else n_pass++;
      $display("test_err: done");
   endtask

   task automatic test_reset_mid_frame();
      int mism;
      apply_reset();
      new_frame(0, 1'b1);
      for (int c = 0; c < 200 && n_acc < 20; c++) step();
      n_checks++; if ({busy, pix_valid} !== 2'b11) $display("FAIL mid_active: got busy %b valid %b expected 1 1", busy, pix_valid); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({busy, pix_valid, s_ready} !== 3'b000) $display("FAIL mid_async_ctl: got %b expected 000", {busy, pix_valid, s_ready}); else n_pass++;
      n_checks++; if ({pix, rows_out, err, frame_done} !== 22'd0) $display("FAIL mid_async_data: got pix %h rows %0d err %b done %b expected zeros", pix, rows_out, err, frame_done); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      intr  = 1'b0;
      new_frame(0, 1'b1);
      run_until_done(2000);
      mism = (got_q.size() == exp_q.size()) ? 0 : 1;
      foreach (got_q[i]) if (i < exp_q.size() && got_q[i] !== exp_q[i]) mism++;
      n_checks++; if (n_writes !== L * W) $display("FAIL mid_rerun_writes: got %0d expected %0d", n_writes, L * W); else n_pass++;
      n_checks++; if (mism !== 0) $display("FAIL mid_rerun_order: got %0d mismatches expected 0", mism); else n_pass++;
      n_checks++; if (n_done !== 1) $display("FAIL mid_rerun_done: got %0d expected 1", n_done); else n_pass++;
      $display("test_reset_mid_frame: rerun %0d writes", n_writes);
   endtask

   task automatic test_random_gate();
      int mism;
      new_frame(50, 1'b1);
      run_until_done(4000);
      mism = (got_q.size() == exp_q.size()) ? 0 : 1;
      foreach (got_q[i]) if (i < exp_q.size() && got_q[i] !== exp_q[i]) mism++;
      n_checks++; if (n_done !== 1) $display("FAIL gate_done: got %0d expected 1", n_done); else n_pass++;
      n_checks++; if (n_writes !== L * W) $display("FAIL gate_writes: got %0d expected %0d", n_writes, L * W); else n_pass++;
      n_checks++; if (mism !== 0) $display("FAIL gate_order: got %0d mismatches expected 0", mism); else n_pass++;
      n_checks++; if (n_spur !== 2 * PAD * W) $display("FAIL gate_unsourced: got %0d expected %0d", n_spur, 2 * PAD * W); else n_pass++;
      n_checks++; if (bad_lat !== 0) $display("FAIL gate_latency: got %0d bad cycles expected 0", bad_lat); else n_pass++;
      n_checks++; if (rows_out !== 12'(L - 2)) $display("FAIL gate_rows: got %0d expected %0d", rows_out, L - 2); else n_pass++;
      $display("test_random_gate: %0d writes in %0d cycles", n_writes, cyc);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_credit_stall();
      test_intr_coincide();
      test_err();
      test_reset_mid_frame();
      test_random_gate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
